pingpong_ctrl: RTL and testbench
================================

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameters: num_rams, default 8, number of parallel RAM lanes per bank; w, default 128, lane width in bits; d, default 128, words per bank (d >= 2); AW = clog2(d).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-003 SHALL have producer ports: wr_vld in 1, word valid; wr_dat in num_rams*w, word data; wr_last in 1, last word of a frame; wr_rdy out 1, word accepted when wr_vld&wr_rdy.
REQ-004 SHALL have consumer ports: rd_avail out 1, a bank has unread words; rd_en in 1, read request; rd_vld out 1, read data valid; rd_dat out num_rams*w, read data; rd_last out 1, final word of the bank; rd_err out 1, sticky flag for rd_en while !rd_avail.
REQ-005 SHALL have bank A RAM ports: we_A out 1; write_addr_A out num_rams*32; din_A out num_rams*w; re_A out 1; read_addr_A out num_rams*32; dout_vld_A in 1; dout_A in num_rams*w. Bank B SHALL have the identical set with suffix _B.
REQ-006 SHALL have status port occ out 2, the count of banks in FULL or DRAINING (0..2).

Function
REQ-007 SHALL give each bank a 2-bit state: EMPTY, FILLING, FULL or DRAINING; a 1-bit write-bank select wsel and a 1-bit read-bank select rsel (0 = A, 1 = B); wr_ptr and rd_ptr of AW bits; and a length register len[bank] of AW+1 bits.
REQ-008 SHALL drive wr_rdy = (state[wsel] == EMPTY or FILLING), combinationally from registered state only; wr_vld SHALL NOT affect wr_rdy.
REQ-009 On an accepted write, SHALL assert we_<wsel> in the same cycle, with din_<wsel> = wr_dat and every 32-bit lane of write_addr_<wsel> = zero-extended wr_ptr. The other bank's we SHALL be 0.
REQ-010 On an accepted write, SHALL apply: if EMPTY, go to FILLING; wr_ptr++. If wr_last, or wr_ptr == d-1: state to FULL, len = wr_ptr+1, wr_ptr = 0, toggle wsel.
REQ-011 SHALL drive rd_avail = (state[rsel] == FULL or DRAINING), from registered state; a bank completing its fill in cycle N SHALL give rd_avail = 1 in cycle N+1, not earlier.
REQ-012 On rd_en & rd_avail, SHALL assert re_<rsel> with every lane of read_addr_<rsel> = rd_ptr. Then: if FULL, go to DRAINING; rd_ptr++. If rd_ptr == len-1: state to EMPTY, rd_ptr = 0, toggle rsel, and mark the read as last.
REQ-013 SHALL make a bank freed by its final read in cycle N writable from cycle N+1; a write to address 0 in N+1 SHALL NOT corrupt the read issued in cycle N.
REQ-014 SHALL register the issuing bank, an in-flight bit and the last mark for each read. rd_vld = in-flight & dout_vld of the registered bank; rd_dat = dout of the registered bank; rd_last = registered last & rd_vld. Latency from rd_en to rd_vld SHALL be the RAM latency (1 cycle).
REQ-015 SHALL ignore rd_en while !rd_avail (no re, no pointer change) and set rd_err = 1 until reset.
REQ-016 SHALL handle a write and a read in the same cycle independently, on different banks or on the same bank (same-bank only via the DRAINING/FILLING handoff of REQ-013). occ SHALL update in the same cycle as the state changes.
REQ-017 SHALL hold a single-word frame (wr_last on the first word) as len = 1.
REQ-018 SHALL hold wr_rdy = 0 when both banks are FULL or DRAINING; it SHALL resume the cycle after the wsel bank becomes EMPTY.

Reset
REQ-019 During rst, SHALL set: both banks EMPTY; wsel = rsel = 0; pointers and len = 0; rd_err = 0; in-flight = 0.
REQ-020 During rst, outputs SHALL be: wr_rdy 1 after reset, rd_avail 0, rd_vld 0, rd_last 0, occ 0, we and re 0, addresses 0.
REQ-021 A reset asserted mid-operation SHALL discard in-flight read data: rd_vld = 0 in the cycle after reset even if dout_vld is 1.

Verification
REQ-022 Fill A with 4 words, wr_last on word 3 -> addresses 0..3 on A; then wr_rdy = 1 with wsel = B; rd_avail = 1 next cycle; occ = 1; len[A] = 4.
REQ-023 Write d = 128 words with no wr_last -> A goes FULL at word 127; word 128 goes to B address 0.
REQ-024 Fill A and B, with no reads -> wr_rdy = 0, occ = 2. Drain A fully -> wr_rdy = 1 one cycle after the last re_A, and the next write goes to A address 0.
REQ-025 Drain 4 words with back-to-back rd_en -> rd_vld for 4 consecutive cycles, each 1 cycle after its rd_en; rd_last only on the 4th; rsel toggles to B.
REQ-026 Pulse rd_en with rd_avail = 0 -> no re_A or re_B, rd_err = 1, held until rst.
REQ-027 Assert rst while a read is in flight -> rd_vld = 0 the next cycle; all state as in REQ-019 and REQ-020.

Source files
------------

// File: rtl/pingpong_ctrl.sv
// Two-bank ping-pong controller: frames fill one RAM bank while the other drains, in frame order.
// Read data returns 1 cycle (RAM latency) after rd_en; wr_rdy drops while both banks hold unread data.
module pingpong_ctrl #(
  parameter int num_rams = 8,
  parameter int w        = 128,
  parameter int d        = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_vld,
  input  logic [num_rams*w-1:0]   wr_dat,
  input  logic                    wr_last,
  output logic                    wr_rdy,
  output logic                    rd_avail,
  input  logic                    rd_en,
  output logic                    rd_vld,
  output logic [num_rams*w-1:0]   rd_dat,
  output logic                    rd_last,
  output logic                    rd_err,
  output logic                    we_A,
  output logic [num_rams*32-1:0]  write_addr_A,
  output logic [num_rams*w-1:0]   din_A,
  output logic                    re_A,
  output logic [num_rams*32-1:0]  read_addr_A,
  input  logic                    dout_vld_A,
  input  logic [num_rams*w-1:0]   dout_A,
  output logic                    we_B,
  output logic [num_rams*32-1:0]  write_addr_B,
  output logic [num_rams*w-1:0]   din_B,
  output logic                    re_B,
  output logic [num_rams*32-1:0]  read_addr_B,
  input  logic                    dout_vld_B,
  input  logic [num_rams*w-1:0]   dout_B,
  output logic [1:0]              occ
);

  localparam int AW = $clog2(d);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_t;

  bank_st_t      state_q [2];
  bank_st_t      state_d [2];
  logic [AW:0]   len_q [2];
  logic [AW:0]   len_d [2];
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_err_q, rd_err_d;
  logic          inflight_q, rbank_q, rlast_q;

  logic          wr_fire, rd_fire, wr_end, rd_end;
  logic [31:0]   wr_lane, rd_lane;

  function automatic logic holds_data(input bank_st_t s);
    return (s == FULL) || (s == DRAINING);
  endfunction

  // Handshake qualifiers come from registered state only; rst masks any RAM strobe.
  always_comb begin
    wr_rdy   = (state_q[wsel_q] == EMPTY) || (state_q[wsel_q] == FILLING);
    rd_avail = holds_data(state_q[rsel_q]) && !rst;
    wr_fire  = wr_vld && wr_rdy && !rst;
    rd_fire  = rd_en && rd_avail;
    wr_end   = wr_last || (wr_ptr_q == AW'(d - 1));
    rd_end   = ({1'b0, rd_ptr_q} == (len_q[rsel_q] - (AW+1)'(1)));
  end

  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_err_d   = rd_err_q || (rd_en && !rd_avail && !rst);

    // Write and read never target the same bank in one cycle: one side needs
    // EMPTY/FILLING, the other FULL/DRAINING.
    if (wr_fire) begin
      if (wr_end) begin
        state_d[wsel_q] = FULL;
        len_d[wsel_q]   = {1'b0, wr_ptr_q} + (AW+1)'(1);
        wr_ptr_d        = '0;
        wsel_d          = !wsel_q;
      end else begin
        state_d[wsel_q] = FILLING;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
    end

    if (rd_fire) begin
      if (rd_end) begin
        state_d[rsel_q] = EMPTY;
        rd_ptr_d        = '0;
        rsel_d          = !rsel_q;
      end else begin
        state_d[rsel_q] = DRAINING;
        rd_ptr_d        = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_err_q   <= 1'b0;
      inflight_q <= 1'b0;
      rbank_q    <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_err_q   <= rd_err_d;
      inflight_q <= rd_fire;
      rbank_q    <= rsel_q;
      rlast_q    <= rd_fire && rd_end;
    end
  end

  always_comb begin
    wr_lane      = 32'(wr_ptr_q);
    rd_lane      = 32'(rd_ptr_q);
    we_A         = wr_fire && !wsel_q;
    we_B         = wr_fire && wsel_q;
    re_A         = rd_fire && !rsel_q;
    re_B         = rd_fire && rsel_q;
    write_addr_A = we_A ? {num_rams{wr_lane}} : '0;
    write_addr_B = we_B ? {num_rams{wr_lane}} : '0;
    read_addr_A  = re_A ? {num_rams{rd_lane}} : '0;
    read_addr_B  = re_B ? {num_rams{rd_lane}} : '0;
    din_A        = wr_dat;
    din_B        = wr_dat;
    // Return path follows the bank captured at issue, not the current rsel.
    rd_vld       = inflight_q && !rst && (rbank_q ? dout_vld_B : dout_vld_A);
    rd_dat       = rbank_q ? dout_B : dout_A;
    rd_last      = rlast_q && rd_vld;
    rd_err       = rd_err_q;
    occ          = rst ? 2'd0 : (2'(holds_data(state_q[0])) + 2'(holds_data(state_q[1])));
  end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Scoreboard bench for pingpong_ctrl: stimulus pushes expected read words, a negedge monitor pops them.
module tb_pingpong_ctrl;

  localparam int NR = 2;
  localparam int W  = 8;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int DW = NR * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_vld = 1'b0;
  logic [DW-1:0]   wr_dat = '0;
  logic            wr_last = 1'b0;
  logic            wr_rdy;
  logic            rd_avail;
  logic            rd_en = 1'b0;
  logic            rd_vld;
  logic [DW-1:0]   rd_dat;
  logic            rd_last;
  logic            rd_err;
  logic            we_A, re_A, we_B, re_B;
  logic [NR*32-1:0] write_addr_A, read_addr_A, write_addr_B, read_addr_B;
  logic [DW-1:0]   din_A, din_B, dout_A, dout_B;
  logic            dout_vld_A, dout_vld_B;
  logic [1:0]      occ;

  logic [DW-1:0]   mem_a [D];
  logic [DW-1:0]   mem_b [D];
  logic            dv_a = 1'b0, dv_b = 1'b0, dv_force = 1'b0;
  logic [DW-1:0]   dq_a = '0, dq_b = '0;

  logic [DW:0]     exp_q [$];
  int              iss_q [$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  pingpong_ctrl #(.num_rams(NR), .w(W), .d(D)) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_last(wr_last), .wr_rdy(wr_rdy),
    .rd_avail(rd_avail), .rd_en(rd_en), .rd_vld(rd_vld), .rd_dat(rd_dat),
    .rd_last(rd_last), .rd_err(rd_err),
    .we_A(we_A), .write_addr_A(write_addr_A), .din_A(din_A), .re_A(re_A),
    .read_addr_A(read_addr_A), .dout_vld_A(dout_vld_A), .dout_A(dout_A),
    .we_B(we_B), .write_addr_B(write_addr_B), .din_B(din_B), .re_B(re_B),
    .read_addr_B(read_addr_B), .dout_vld_B(dout_vld_B), .dout_B(dout_B),
    .occ(occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle RAM per bank; a read and a write in the same cycle see old data.
  always @(posedge clk) begin
    dv_a <= re_A;
    dv_b <= re_B;
    if (re_A) dq_a <= mem_a[read_addr_A[AW-1:0]];
    if (re_B) dq_b <= mem_b[read_addr_B[AW-1:0]];
    if (we_A) mem_a[write_addr_A[AW-1:0]] <= din_A;
    if (we_B) mem_b[write_addr_B[AW-1:0]] <= din_B;
  end
  assign dout_vld_A = dv_a | dv_force;
  assign dout_vld_B = dv_b;
  assign dout_A = dq_a;
  assign dout_B = dq_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus, entered and left just after a rising edge.
  task automatic step(input bit wv, input bit wacc, input logic [DW-1:0] dat, input bit last,
                      input bit wbank, input int waddr,
                      input bit rv, input bit racc, input bit rbank, input int raddr,
                      input int exp_occ);
    logic [NR*32-1:0] ea;
    wr_vld = wv; wr_dat = dat; wr_last = last; rd_en = rv;
    @(negedge clk);
    if (wv) chk("wr_rdy", 64'(wr_rdy), 64'(wacc));
    chk("we_A", 64'(we_A), 64'(wacc & ~wbank));
    chk("we_B", 64'(we_B), 64'(wacc & wbank));
    if (wacc) begin
      ea = {NR{32'(waddr)}};
      chk("write_addr", 64'(wbank ? write_addr_B : write_addr_A), 64'(ea));
      chk("din", 64'(wbank ? din_B : din_A), 64'(dat));
      exp_q.push_back({(last || (waddr == D - 1)), dat});
    end
    if (rv) chk("rd_avail", 64'(rd_avail), 64'(racc));
    chk("re_A", 64'(re_A), 64'(racc & ~rbank));
    chk("re_B", 64'(re_B), 64'(racc & rbank));
    if (racc) begin
      ea = {NR{32'(raddr)}};
      chk("read_addr", 64'(rbank ? read_addr_B : read_addr_A), 64'(ea));
      iss_q.push_back(cyc);
    end
    chk("occ", 64'(occ), 64'(exp_occ));
    chk("rd_avail_vs_occ", 64'(rd_avail), 64'(exp_occ != 0));
    @(posedge clk); #1;
    wr_vld = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] dat, input bit last, input bit bank, input int addr,
                    input int o);
    step(1'b1, 1'b1, dat, last, bank, addr, 1'b0, 1'b0, 1'b0, 0, o);
  endtask

  task automatic rd(input bit bank, input int addr, input int o);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b1, bank, addr, o);
  endtask

  task automatic idle(input int o);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, o);
  endtask

  // Requests are held high during reset to show that reset masks the RAM strobes.
  task automatic do_reset();
    rst = 1'b1; wr_vld = 1'b1; wr_dat = 16'hdead; rd_en = 1'b1;
    exp_q.delete(); iss_q.delete();
    @(negedge clk);
    chk("rst_we", 64'({we_A, we_B}), 64'(0));
    chk("rst_re", 64'({re_A, re_B}), 64'(0));
    chk("rst_rd_vld", 64'(rd_vld), 64'(0));
    chk("rst_rd_avail", 64'(rd_avail), 64'(0));
    chk("rst_occ", 64'(occ), 64'(0));
    chk("rst_addr", 64'(write_addr_A | write_addr_B | read_addr_A | read_addr_B), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; wr_vld = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_rdy", 64'(wr_rdy), 64'(1));
    chk("post_rst_rd_avail", 64'(rd_avail), 64'(0));
    chk("post_rst_rd_vld", 64'(rd_vld), 64'(0));
    chk("post_rst_rd_last", 64'(rd_last), 64'(0));
    chk("post_rst_occ", 64'(occ), 64'(0));
    chk("post_rst_rd_err", 64'(rd_err), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    logic [DW:0] e;
    int ic;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (exp_q.size() == 0 || iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_vld_unexpected: rd_vld=1 with no outstanding read (cycle %0d)", cyc);
        end else begin
          e  = exp_q.pop_front();
          ic = iss_q.pop_front();
          chk("rd_dat", 64'(rd_dat), 64'(e[DW-1:0]));
          chk("rd_last", 64'(rd_last), 64'(e[DW]));
          chk("rd_latency", 64'(cyc - ic), 64'(1));
        end
      end else begin
        chk("rd_last_idle", 64'(rd_last), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    do_reset();

    // Four-word frame into A, then a single-word frame into B, then drain both.
    for (int i = 0; i < 4; i++) wr(16'h1000 + 16'(i), (i == 3), 1'b0, i, 0);
    idle(1);
    wr(16'h2000, 1'b1, 1'b1, 0, 1);
    for (int i = 0; i < 4; i++) rd(1'b0, i, 2);
    rd(1'b1, 0, 1);
    idle(0);

    // A full-depth frame with no wr_last; the next word starts B at address 0.
    for (int i = 0; i < D; i++) wr(16'h3000 + 16'(i), 1'b0, 1'b0, i, 0);
    wr(16'h4000, 1'b0, 1'b1, 0, 1);
    wr(16'h4001, 1'b0, 1'b1, 1, 1);
    wr(16'h4002, 1'b1, 1'b1, 2, 1);

    // Both banks full: writes stall until A is drained.
    idle(2);
    step(1'b1, 1'b0, 16'hbad0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 2);
    step(1'b1, 1'b0, 16'hbad0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 2);
    for (int i = 0; i < D - 1; i++) rd(1'b0, i, 2);
    step(1'b1, 1'b0, 16'hbad1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, D - 1, 2);
    wr(16'h5000, 1'b1, 1'b0, 0, 1);

    // Bank handoff: a bank freed by its final read is refilled the next cycle.
    rd(1'b1, 0, 2);
    rd(1'b1, 1, 2);
    rd(1'b1, 2, 2);
    step(1'b1, 1'b1, 16'h6000, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 1);
    wr(16'h7000, 1'b1, 1'b0, 0, 1);
    rd(1'b1, 0, 2);
    step(1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 1);
    rd(1'b1, 0, 1);
    idle(0);

    // Read with nothing available: no RAM read, sticky error.
    chk("rd_err_before", 64'(rd_err), 64'(0));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(0);
    chk("rd_err_set", 64'(rd_err), 64'(1));
    idle(0);
    chk("rd_err_held", 64'(rd_err), 64'(1));

    // Reset while a read is in flight, with the RAM valid forced high.
    wr(16'h9000, 1'b0, 1'b0, 0, 0);
    wr(16'h9001, 1'b1, 1'b0, 1, 0);
    rd(1'b0, 0, 1);
    dv_force = 1'b1;
    chk("rd_err_pre_rst", 64'(rd_err), 64'(1));
    do_reset();
    dv_force = 1'b0;
    wr(16'ha000, 1'b1, 1'b0, 0, 0);
    rd(1'b0, 0, 1);
    idle(0);
    idle(0);

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("iss_q_drained", 64'(iss_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
